// File: rtl/dffnsre_bank_ctrl.sv
// dffnsre_bank_ctrl
//   Command sequencer for a bank of WIDTH negative-edge dffnsre flops sharing E/R/S and an
//   output-gating select. Accepts LOAD/CLEAR/PRESET/SHOW over valid/ready and drives the bank
//   controls with safe ordering: one active control phase, a settle cycle with everything low,
//   then an optional show window. A shadow copy of the expected bank contents is kept alongside.
//
// Ports
//   C          in   clock (controller on posedge; bank samples on negedge)
//   R          in   asynchronous active-high reset
//   cmd_valid  in   command present
//   cmd_ready  out  high only in IDLE
//   cmd_op     in   00 LOAD, 01 CLEAR, 10 PRESET, 11 SHOW
//   cmd_data   in   load value (LOAD only)
//   abort      in   terminate current command, back to IDLE without done
//   E_o/R_o/S_o out bank enable / clear / preset
//   D_o        out  bank data, holds last loaded value
//   sel_o      out  bank output select (1 = flop values visible)
//   busy       out  state != IDLE
//   done       out  one-cycle pulse in the first IDLE cycle after normal completion
//   q_exp      out  shadow of expected bank contents
//   q_exp_vld  out  shadow valid
module dffnsre_bank_ctrl #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned PULSE_CYCLES = 1,
    parameter int unsigned SHOW_CYCLES  = 4
) (
    input  logic             C,
    input  logic             R,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             abort,
    output logic             E_o,
    output logic             R_o,
    output logic             S_o,
    output logic [WIDTH-1:0] D_o,
    output logic             sel_o,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q_exp,
    output logic             q_exp_vld
);

    localparam logic [1:0] OpLoad   = 2'b00;
    localparam logic [1:0] OpClear  = 2'b01;
    localparam logic [1:0] OpPreset = 2'b10;
    localparam logic [1:0] OpShow   = 2'b11;

    localparam int unsigned MaxCyc = (PULSE_CYCLES > SHOW_CYCLES) ? PULSE_CYCLES : SHOW_CYCLES;
    localparam int unsigned CntW   = $clog2(MaxCyc + 1);
    localparam logic [CntW-1:0] PulseLd = CntW'(PULSE_CYCLES - 1);
    localparam logic [CntW-1:0] ShowLd  = CntW'((SHOW_CYCLES > 0) ? SHOW_CYCLES - 1 : 0);

    typedef enum logic [2:0] {StIdle, StClr, StSet, StLoad, StSettle, StShow} state_t;

    state_t            r_state;
    logic [CntW-1:0]   r_cnt;
    logic              r_e;
    logic              r_r;
    logic              r_s;
    logic              r_sel;
    logic              r_done;
    logic [WIDTH-1:0]  r_d;
    logic [WIDTH-1:0]  r_q;
    logic              r_vld;
    logic              w_idle;

    assign w_idle    = (r_state == StIdle);
    assign cmd_ready = w_idle;
    assign busy      = ~w_idle;
    assign E_o       = r_e;
    assign R_o       = r_r;
    assign S_o       = r_s;
    assign D_o       = r_d;
    assign sel_o     = r_sel;
    assign done      = r_done;
    assign q_exp     = r_q;
    assign q_exp_vld = r_vld;

    // Outputs are registered together with the state they belong to, so each output
    // reflects the state entered at the same edge.
    always_ff @(posedge C or posedge R) begin
        if (R) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_e     <= 1'b0;
            r_r     <= 1'b0;
            r_s     <= 1'b0;
            r_sel   <= 1'b0;
            r_done  <= 1'b0;
            r_d     <= '0;
            r_q     <= '0;
            r_vld   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (!w_idle && abort) begin
                r_state <= StIdle;
                r_e     <= 1'b0;
                r_r     <= 1'b0;
                r_s     <= 1'b0;
                r_sel   <= 1'b0;
                // Bank may have been partially written: shadow can no longer be trusted.
                if (r_state inside {StClr, StSet, StLoad}) begin
                    r_vld <= 1'b0;
                end
            end else begin
                unique case (r_state)
                    StIdle: begin
                        if (cmd_valid) begin
                            unique case (cmd_op)
                                OpLoad: begin
                                    r_state <= StLoad;
                                    r_e     <= 1'b1;
                                    r_d     <= cmd_data;
                                end
                                OpClear: begin
                                    r_state <= StClr;
                                    r_r     <= 1'b1;
                                    r_cnt   <= PulseLd;
                                end
                                OpPreset: begin
                                    r_state <= StSet;
                                    r_s     <= 1'b1;
                                    r_cnt   <= PulseLd;
                                end
                                OpShow: begin
                                    if (SHOW_CYCLES == 0) begin
                                        r_done <= 1'b1;
                                    end else begin
                                        r_state <= StShow;
                                        r_sel   <= 1'b1;
                                        r_cnt   <= ShowLd;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                    StClr: begin
                        if (r_cnt == '0) begin
                            r_state <= StSettle;
                            r_r     <= 1'b0;
                            r_q     <= '0;
                            r_vld   <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    StSet: begin
                        if (r_cnt == '0) begin
                            r_state <= StSettle;
                            r_s     <= 1'b0;
                            r_q     <= '1;
                            r_vld   <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    StLoad: begin
                        r_state <= StSettle;
                        r_e     <= 1'b0;
                        r_q     <= r_d;
                        r_vld   <= 1'b1;
                    end
                    StSettle: begin
                        if (SHOW_CYCLES == 0) begin
                            r_state <= StIdle;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= StShow;
                            r_sel   <= 1'b1;
                            r_cnt   <= ShowLd;
                        end
                    end
                    StShow: begin
                        if (r_cnt == '0) begin
                            r_state <= StIdle;
                            r_sel   <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    default: begin
                        r_state <= StIdle;
                        r_e     <= 1'b0;
                        r_r     <= 1'b0;
                        r_s     <= 1'b0;
                        r_sel   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dffnsre_bank_ctrl.sv
module tb_dffnsre_bank_ctrl;

    localparam int W  = 8;
    localparam int NI = 3;

    logic         C = 1'b0;
    logic         rst = 1'b0;
    logic         cmd_valid = 1'b0;
    logic [1:0]   cmd_op = 2'd0;
    logic [W-1:0] cmd_data = '0;
    logic         abort = 1'b0;

    logic [NI-1:0] ready, e_o, r_o, s_o, sel_o, busy, done, vld;
    logic [W-1:0]  d_o [NI];
    logic [W-1:0]  q_o [NI];

    always #5 C = ~C;

    // Instance 0: defaults; 1: long pulse; 2: no show phase.
    dffnsre_bank_ctrl #(.WIDTH(W), .PULSE_CYCLES(1), .SHOW_CYCLES(4)) u_dut0 (
        .C(C), .R(rst), .cmd_valid(cmd_valid), .cmd_ready(ready[0]), .cmd_op(cmd_op),
        .cmd_data(cmd_data), .abort(abort), .E_o(e_o[0]), .R_o(r_o[0]), .S_o(s_o[0]),
        .D_o(d_o[0]), .sel_o(sel_o[0]), .busy(busy[0]), .done(done[0]), .q_exp(q_o[0]),
        .q_exp_vld(vld[0]));
    dffnsre_bank_ctrl #(.WIDTH(W), .PULSE_CYCLES(3), .SHOW_CYCLES(4)) u_dut1 (
        .C(C), .R(rst), .cmd_valid(cmd_valid), .cmd_ready(ready[1]), .cmd_op(cmd_op),
        .cmd_data(cmd_data), .abort(abort), .E_o(e_o[1]), .R_o(r_o[1]), .S_o(s_o[1]),
        .D_o(d_o[1]), .sel_o(sel_o[1]), .busy(busy[1]), .done(done[1]), .q_exp(q_o[1]),
        .q_exp_vld(vld[1]));
    dffnsre_bank_ctrl #(.WIDTH(W), .PULSE_CYCLES(1), .SHOW_CYCLES(0)) u_dut2 (
        .C(C), .R(rst), .cmd_valid(cmd_valid), .cmd_ready(ready[2]), .cmd_op(cmd_op),
        .cmd_data(cmd_data), .abort(abort), .E_o(e_o[2]), .R_o(r_o[2]), .S_o(s_o[2]),
        .D_o(d_o[2]), .sel_o(sel_o[2]), .busy(busy[2]), .done(done[2]), .q_exp(q_o[2]),
        .q_exp_vld(vld[2]));

    // Reference model: each accepted command becomes a per-cycle schedule of expected
    // control values (kind 0 = active phase, 1 = settle, 2 = show).
    typedef struct packed {
        logic [1:0]   kind;
        logic         e;
        logic         r;
        logic         s;
        logic         sel;
        logic [W-1:0] upd;
    } rec_t;

    rec_t         sched [NI][16];
    int           len [NI];
    int           pc [NI];
    int           nc [NI];
    logic [W-1:0] m_d [NI];
    logic [W-1:0] m_q [NI];
    logic         m_vld [NI];
    logic         m_done [NI];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic rec_t mk(input logic [1:0] kind, input logic e, input logic r,
                                input logic s, input logic sel, input logic [W-1:0] upd);
        rec_t x;
        x.kind = kind; x.e = e; x.r = r; x.s = s; x.sel = sel; x.upd = upd;
        return x;
    endfunction

    task automatic push(input int k, input rec_t x);
        sched[k][len[k]] = x;
        len[k]++;
    endtask

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            len[k] = 0; m_d[k] = '0; m_q[k] = '0; m_vld[k] = 1'b0; m_done[k] = 1'b0;
        end
    endtask

    task automatic model_step();
        logic nd;
        if (rst) begin
            model_reset();
            return;
        end
        for (int k = 0; k < NI; k++) begin
            nd = 1'b0;
            if (len[k] > 0) begin
                if (abort) begin
                    if (sched[k][0].kind == 2'd0) m_vld[k] = 1'b0;
                    len[k] = 0;
                end else begin
                    for (int i = 0; i < 15; i++) sched[k][i] = sched[k][i+1];
                    len[k]--;
                    if (len[k] == 0) nd = 1'b1;
                    else if (sched[k][0].kind == 2'd1) begin
                        m_q[k] = sched[k][0].upd;
                        m_vld[k] = 1'b1;
                    end
                end
            end else if (cmd_valid) begin
                case (cmd_op)
                    2'd0: begin
                        m_d[k] = cmd_data;
                        push(k, mk(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, '0));
                        push(k, mk(2'd1, 1'b0, 1'b0, 1'b0, 1'b0, cmd_data));
                    end
                    2'd1: begin
                        for (int i = 0; i < pc[k]; i++) push(k, mk(2'd0, 1'b0, 1'b1, 1'b0, 1'b0, '0));
                        push(k, mk(2'd1, 1'b0, 1'b0, 1'b0, 1'b0, '0));
                    end
                    2'd2: begin
                        for (int i = 0; i < pc[k]; i++) push(k, mk(2'd0, 1'b0, 1'b0, 1'b1, 1'b0, '0));
                        push(k, mk(2'd1, 1'b0, 1'b0, 1'b0, 1'b0, '1));
                    end
                    default: ;
                endcase
                for (int i = 0; i < nc[k]; i++) push(k, mk(2'd2, 1'b0, 1'b0, 1'b0, 1'b1, '0));
                if (len[k] == 0) nd = 1'b1;
            end
            m_done[k] = nd;
        end
    endtask

    task automatic check_all();
        logic [7:0] exp_c, got_c;
        for (int k = 0; k < NI; k++) begin
            if (len[k] > 0)
                exp_c = {sched[k][0].e, sched[k][0].r, sched[k][0].s, sched[k][0].sel,
                         1'b1, m_done[k], 1'b0, m_vld[k]};
            else
                exp_c = {4'b0000, 1'b0, m_done[k], 1'b1, m_vld[k]};
            got_c = {e_o[k], r_o[k], s_o[k], sel_o[k], busy[k], done[k], ready[k], vld[k]};
            check($sformatf("ctrl%0d{e,r,s,sel,busy,done,rdy,vld}", k), 32'(got_c), 32'(exp_c));
            check($sformatf("d_o%0d", k), 32'(d_o[k]), 32'(m_d[k]));
            check($sformatf("q_exp%0d", k), 32'(q_o[k]), 32'(m_q[k]));
            check($sformatf("inv%0d{rs,e_rs}", k),
                  {30'd0, r_o[k] & s_o[k], e_o[k] & (r_o[k] | s_o[k])}, 32'd0);
        end
    endtask

    task automatic cycle();
        @(posedge C);
        model_step();
        @(negedge C);
        check_all();
    endtask

    task automatic idle_cycles(input int n);
        cmd_valid = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        pc = '{1, 3, 1};
        nc = '{4, 4, 0};
        model_reset();
        rst = 1'b1;
        @(negedge C);
        check_all();
        cycle();
        rst = 1'b0;
        idle_cycles(1);

        // LOAD 0xA5
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_data = 8'hA5;
        cycle();
        idle_cycles(12);

        // CLEAR
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_data = 8'h5A;
        cycle();
        idle_cycles(12);

        // PRESET then SHOW with valid held
        cmd_valid = 1'b1; cmd_op = 2'd2;
        cycle();
        cmd_op = 2'd3;
        for (int i = 0; i < 14; i++) cycle();
        idle_cycles(10);

        // LOAD 0x3C aborted one cycle later
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_data = 8'h3C;
        cycle();
        cmd_valid = 1'b0; abort = 1'b1;
        cycle();
        abort = 1'b0;
        check("abort_vld0", 32'(vld[0]), 32'd0);
        idle_cycles(8);

        // Reset asserted mid-SHOW, checked before the next clock edge
        cmd_valid = 1'b1; cmd_op = 2'd3;
        cycle();
        cmd_valid = 1'b0;
        cycle();
        check("show_sel_before_rst", 32'(sel_o[0]), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_sel", 32'(sel_o[0]), 32'd0);
        check("async_rst_busy", 32'(busy[0]), 32'd0);
        model_reset();
        check_all();
        cycle();
        rst = 1'b0;
        idle_cycles(2);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            cmd_valid = ($urandom_range(0, 9) < 6);
            cmd_op    = 2'($urandom_range(0, 3));
            cmd_data  = W'($urandom);
            abort     = ($urandom_range(0, 19) == 0);
            rst       = ($urandom_range(0, 199) == 0);
            cycle();
        end
        rst = 1'b0; abort = 1'b0;
        idle_cycles(12);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
